// File: rtl/seq_detect_ctrl.sv
// seq_detect_ctrl: configurable serial pattern detector with Moore detect
// output, saturating detection counter and a valid/ready event flag.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   en, din           run enable and serial data bit (sampled when en=1)
//   cfg_wr            config write strobe (accepted only in IDLE with en=0)
//   cfg_pattern       target pattern, bit [cfg_len] first received, bit 0 last
//   cfg_len           pattern length minus one
//   cfg_overlap       1 = overlapping detection, 0 = non-overlapping
//   cfg_err           one-cycle pulse after a rejected cfg_wr
//   det               high for one cycle per match (state MATCH)
//   det_count         saturating detection count
//   evt_valid/ready   detection event handshake
//   evt_ovf           sticky: detection while an event was still pending
module seq_detect_ctrl #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             din,
    input  logic             cfg_wr,
    input  logic [7:0]       cfg_pattern,
    input  logic [2:0]       cfg_len,
    input  logic             cfg_overlap,
    output logic             cfg_err,
    output logic             det,
    output logic [CNT_W-1:0] det_count,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic             evt_ovf
);

    localparam int unsigned HIST_W = 8;
    localparam int unsigned FILL_W = 4;
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(HIST_W);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        MATCH = 2'd2
    } state_t;

    state_t              state_q;
    logic [HIST_W-1:0]   hist_q;
    logic [FILL_W-1:0]   fill_q;
    logic [7:0]          pat_q;
    logic [2:0]          len_q;
    logic                ovl_q;

    logic [HIST_W-1:0]   hist_nx_c;
    logic [FILL_W-1:0]   fill_nx_c;
    logic [HIST_W-1:0]   mask_c;
    logic                match_c;
    logic                cfg_ok_c;

    // Post-shift history/fill and the match decision for this edge
    always_comb begin
        hist_nx_c = {hist_q[HIST_W-2:0], din};
        fill_nx_c = (fill_q == FILL_MAX) ? FILL_MAX : fill_q + FILL_W'(1);
        mask_c    = '0;
        for (int i = 0; i < HIST_W; i++) begin
            mask_c[i] = (3'(i) <= len_q);
        end
        match_c  = en
                 && (fill_nx_c >= (FILL_W'(len_q) + FILL_W'(1)))
                 && (((hist_nx_c ^ pat_q) & mask_c) == '0);
        cfg_ok_c = cfg_wr && (state_q == IDLE) && !en;
    end

    // Control FSM, history, counters and event flags
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            hist_q    <= '0;
            fill_q    <= '0;
            pat_q     <= 8'b0000_1010;
            len_q     <= 3'd3;
            ovl_q     <= 1'b0;
            det       <= 1'b0;
            det_count <= '0;
            evt_valid <= 1'b0;
            evt_ovf   <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            cfg_err <= cfg_wr && !cfg_ok_c;
            if (cfg_ok_c) begin
                pat_q <= cfg_pattern;
                len_q <= cfg_len;
                ovl_q <= cfg_overlap;
            end

            if (!en) begin
                state_q <= IDLE;
                hist_q  <= '0;
                fill_q  <= '0;
                det     <= 1'b0;
            end else begin
                hist_q <= hist_nx_c;
                if (match_c) begin
                    state_q <= MATCH;
                    det     <= 1'b1;
                    // Non-overlap: discard matched bits so none are reused
                    fill_q  <= ovl_q ? fill_nx_c : '0;
                end else begin
                    state_q <= RUN;
                    det     <= 1'b0;
                    fill_q  <= fill_nx_c;
                end
            end

            if (match_c && (det_count != CNT_MAX)) begin
                det_count <= det_count + CNT_W'(1);
            end

            // A new match wins over a same-edge handshake; overflow only if unaccepted
            if (match_c) begin
                evt_valid <= 1'b1;
                if (evt_valid && !evt_ready) begin
                    evt_ovf <= 1'b1;
                end
            end else if (evt_valid && evt_ready) begin
                evt_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Self-checking bench for seq_detect_ctrl: directed scenarios followed by
// random stimulus, compared against a bit-list reference model.
module tb_seq_detect_ctrl;

    logic       clk = 1'b0;
    logic       reset, en, din, cfg_wr, cfg_overlap, evt_ready;
    logic [7:0] cfg_pattern;
    logic [2:0] cfg_len;

    logic       cfg_err, det, evt_valid, evt_ovf;
    logic [7:0] det_count;
    logic       cfg_err2, det2, evt_valid2, evt_ovf2;
    logic [1:0] det_count2;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    seq_detect_ctrl dut (
        .clk(clk), .reset(reset), .en(en), .din(din), .cfg_wr(cfg_wr),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
        .cfg_err(cfg_err), .det(det), .det_count(det_count),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_ovf(evt_ovf)
    );

    seq_detect_ctrl #(.CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .en(en), .din(din), .cfg_wr(cfg_wr),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
        .cfg_err(cfg_err2), .det(det2), .det_count(det_count2),
        .evt_valid(evt_valid2), .evt_ready(evt_ready), .evt_ovf(evt_ovf2)
    );

    // Reference model: list of bits still eligible to form a match
    logic       m_q[$];
    bit         m_idle;
    bit         m_det, m_ev, m_ovf, m_err;
    int         m_cnt8, m_cnt2;
    logic [7:0] m_pat;
    int         m_len;
    bit         m_ovl;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_edge(input bit r, input bit e, input bit d, input bit w,
                              input logic [7:0] p, input logic [2:0] l, input bit o,
                              input bit rdy);
        bit m;
        m = 1'b0;
        if (r) begin
            m_idle = 1; m_q.delete(); m_det = 0; m_cnt8 = 0; m_cnt2 = 0;
            m_ev = 0; m_ovf = 0; m_err = 0;
            m_pat = 8'h0A; m_len = 3; m_ovl = 0;
            return;
        end
        m_err = w && !(m_idle && !e);
        if (w && m_idle && !e) begin
            m_pat = p; m_len = int'(l); m_ovl = o;
        end
        if (!e) begin
            m_idle = 1; m_q.delete(); m_det = 0;
        end else begin
            m_idle = 0;
            m_q.push_back(d);
            if (m_q.size() > 8) void'(m_q.pop_front());
            if (m_q.size() >= m_len + 1) begin
                m = 1'b1;
                // most recent bit lines up with pattern bit 0
                for (int k = 0; k <= m_len; k++)
                    if (m_q[m_q.size() - 1 - k] !== m_pat[k]) m = 1'b0;
            end
            m_det = m;
            if (m) begin
                if (m_cnt8 < 255) m_cnt8++;
                if (m_cnt2 < 3) m_cnt2++;
                if (!m_ovl) m_q.delete();
            end
        end
        if (m) begin
            if (m_ev && !rdy) m_ovf = 1;
            m_ev = 1;
        end else if (m_ev && rdy) begin
            m_ev = 0;
        end
    endtask

    // Apply one cycle of inputs, advance model, compare all outputs
    task automatic step(input bit r, input bit e, input bit d, input bit w,
                        input logic [7:0] p, input logic [2:0] l, input bit o,
                        input bit rdy);
        reset = r; en = e; din = d; cfg_wr = w;
        cfg_pattern = p; cfg_len = l; cfg_overlap = o;
        evt_ready = rdy;
        @(posedge clk);
        model_edge(r, e, d, w, p, l, o, rdy);
        #1;
        check("det",       32'(det),        32'(m_det));
        check("det_count", 32'(det_count),  32'(m_cnt8));
        check("det_cnt2",  32'(det_count2), 32'(m_cnt2));
        check("evt_valid", 32'(evt_valid),  32'(m_ev));
        check("evt_ovf",   32'(evt_ovf),    32'(m_ovf));
        check("cfg_err",   32'(cfg_err),    32'(m_err));
    endtask

    task automatic do_reset();
        step(1, 0, 0, 0, 8'h00, 3'd0, 0, 0);
    endtask

    task automatic idle_cycle();
        step(0, 0, 0, 0, 8'h00, 3'd0, 0, 0);
    endtask

    task automatic cfg(input logic [7:0] p, input logic [2:0] l, input bit o);
        idle_cycle();
        step(0, 0, 0, 1, p, l, o, 0);
    endtask

    // Feed n bits MSB-first from bits[n-1:0]
    task automatic feed(input logic [15:0] bits, input int n, input bit rdy);
        logic [15:0] b;
        b = bits;
        for (int i = n - 1; i >= 0; i--) step(0, 1, b[i], 0, 8'h00, 3'd0, 0, rdy);
    endtask

    initial begin
        bit       e_r;
        int unsigned rv;
        reset = 1; en = 0; din = 0; cfg_wr = 0;
        cfg_pattern = 0; cfg_len = 0; cfg_overlap = 0; evt_ready = 0;

        do_reset();
        check("rst_det_direct", 32'(det), 32'(0));

        // Default 1010, non-overlap
        feed(16'b101010, 6, 1);
        check("dflt_count", 32'(det_count), 32'(1));

        // Overlap mode
        cfg(8'h0A, 3'd3, 1);
        feed(16'b101010, 6, 1);
        check("ovl_count", 32'(det_count), 32'(3));

        // 3-bit 110 pattern, plus a rejected write mid-stream
        cfg(8'b110, 3'd2, 0);
        feed(16'b1110110, 7, 1);
        step(0, 1, 1, 1, 8'hFF, 3'd0, 1, 1);
        check("rej_err", 32'(cfg_err), 32'(1));
        feed(16'b10, 2, 1);
        check("rej_cfg_kept", 32'(det), 32'(1));

        // Overflow: two detections without ready, then one ready cycle
        do_reset();
        feed(16'b10101010, 8, 0);
        check("ovf_set", 32'(evt_ovf), 32'(1));
        step(0, 1, 0, 0, 8'h00, 3'd0, 0, 1);
        check("ovf_clr_valid", 32'(evt_valid), 32'(0));
        check("ovf_sticky", 32'(evt_ovf), 32'(1));

        // Saturation of the 2-bit counter
        do_reset();
        for (int i = 0; i < 5; i++) feed(16'b1010, 4, 1);
        check("sat2", 32'(det_count2), 32'(3));

        // Reset mid-pattern
        do_reset();
        feed(16'b101, 3, 1);
        do_reset();
        feed(16'b0, 1, 1);
        check("midrst_nodet", 32'(det), 32'(0));
        feed(16'b1010, 4, 1);
        check("midrst_count", 32'(det_count), 32'(1));

        // Random stimulus; ready only driven while running
        e_r = 1;
        for (int i = 0; i < 3000; i++) begin
            rv = $urandom;
            if (rv[4:0] == 0) e_r = !e_r;
            step(rv[15:8] == 0,
                 e_r,
                 rv[5],
                 e_r ? (rv[23:20] == 0) : (rv[23:21] == 0),
                 8'($urandom),
                 (rv[24] ? 3'($urandom_range(0, 3)) : 3'($urandom)),
                 rv[25],
                 e_r && rv[26]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
